// File: rtl/debounce_timer_bank.sv
// Shared debounce timing: one prescaler produces a common tick, and each channel
// runs a CLEAR/COUNT/DONE timer against a programmable tick limit.
module debounce_timer_bank #(
  parameter int CHANNELS      = 4,
  parameter int PRESCALE      = 50000,
  parameter int CNT_W         = 8,
  parameter int DEFAULT_LIMIT = 20
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       timer_reset,
  output logic [CHANNELS-1:0]       timer_done,
  input  logic                      cfg_we,
  input  logic [CNT_W-1:0]          cfg_limit,
  output logic [CNT_W-1:0]          limit,
  output logic                      tick,
  output logic [2*CHANNELS-1:0]     dbg_state,
  output logic [CHANNELS*CNT_W-1:0] dbg_count
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic                run_q;
  logic [CNT_W-1:0]    limit_q, limit_d;
  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_d   [CHANNELS];
  logic [CNT_W:0]      cnt_inc [CHANNELS];
  logic [CHANNELS-1:0] done_q, done_d;

  // run_q keeps tick low while in reset even when PRESCALE is 1.
  assign tick       = run_q && (pre_cnt_q == PRE_MAX);
  assign timer_done = done_q;
  assign limit      = limit_q;

  always_comb begin
    pre_cnt_d = (pre_cnt_q == PRE_MAX) ? '0 : pre_cnt_q + PRE_W'(1);
    limit_d   = limit_q;
    if (cfg_we) begin
      limit_d = (cfg_limit == '0) ? CNT_W'(1) : cfg_limit;
    end
  end

  always_comb begin
    done_d = done_q;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      cnt_inc[i] = {1'b0, cnt_q[i]} + (CNT_W + 1)'(1);
      case (state_q[i])
        ST_CLEAR: begin
          cnt_d[i]  = '0;
          done_d[i] = 1'b0;
          // Leaving CLEAR never reaches DONE directly, so a stale done cannot appear.
          if (!timer_reset[i]) begin
            state_d[i] = ST_COUNT;
            if (tick) cnt_d[i] = CNT_W'(1);
          end
        end
        ST_COUNT: begin
          if (timer_reset[i]) begin
            state_d[i] = ST_CLEAR;
            cnt_d[i]   = '0;
            done_d[i]  = 1'b0;
          end else if (tick) begin
            cnt_d[i] = cnt_inc[i][CNT_W] ? cnt_q[i] : cnt_inc[i][CNT_W-1:0];
            if (cnt_inc[i] >= {1'b0, limit_q}) begin
              state_d[i] = ST_DONE;
              done_d[i]  = 1'b1;
            end
          end
        end
        ST_DONE: begin
          done_d[i] = 1'b1;
          if (timer_reset[i]) begin
            state_d[i] = ST_CLEAR;
            cnt_d[i]   = '0;
            done_d[i]  = 1'b0;
          end
        end
        default: begin
          state_d[i] = ST_CLEAR;
          cnt_d[i]   = '0;
          done_d[i]  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      dbg_state[2*i +: 2]       = state_q[i];
      dbg_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q <= '0;
      run_q     <= 1'b0;
      limit_q   <= CNT_W'(DEFAULT_LIMIT);
      done_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_CLEAR;
        cnt_q[i]   <= '0;
      end
    end else begin
      pre_cnt_q <= pre_cnt_d;
      run_q     <= 1'b1;
      limit_q   <= limit_d;
      done_q    <= done_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_debounce_timer_bank.sv
// Directed bench for debounce_timer_bank: a PRESCALE=4/limit=3 instance and a
// PRESCALE=1/limit=1 instance, with cycle-accurate hand-computed expectations.
module tb_debounce_timer_bank;

  logic        clk;
  logic        reset_n;

  logic [3:0]  tr, done;
  logic        cfg_we;
  logic [7:0]  cfg_limit, limit;
  logic        tick;
  logic [7:0]  dbg_state;
  logic [31:0] dbg_count;

  logic [3:0]  tr1, done1;
  logic        cfg_we1;
  logic [7:0]  cfg_limit1, limit1;
  logic        tick1;
  logic [7:0]  dbg_state1;
  logic [31:0] dbg_count1;

  int checks = 0;
  int errors = 0;

  debounce_timer_bank #(
    .CHANNELS(4), .PRESCALE(4), .CNT_W(8), .DEFAULT_LIMIT(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .timer_reset(tr), .timer_done(done),
    .cfg_we(cfg_we), .cfg_limit(cfg_limit), .limit(limit), .tick(tick),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  debounce_timer_bank #(
    .CHANNELS(4), .PRESCALE(1), .CNT_W(8), .DEFAULT_LIMIT(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .timer_reset(tr1), .timer_done(done1),
    .cfg_we(cfg_we1), .cfg_limit(cfg_limit1), .limit(limit1), .tick(tick1),
    .dbg_state(dbg_state1), .dbg_count(dbg_count1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task next_edge();
    @(posedge clk);
    #1;
  endtask

  // After this returns, the current observation is "cycle 0" (before edge 0).
  task apply_reset(input logic [3:0] tr_val);
    reset_n    = 1'b0;
    tr         = tr_val;
    tr1        = 4'hF;
    cfg_we     = 1'b0;
    cfg_limit  = 8'd0;
    cfg_we1    = 1'b0;
    cfg_limit1 = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task test_reset();
    reset_n = 1'b0;
    tr = 4'h0; tr1 = 4'hF; cfg_we = 1'b0; cfg_limit = 8'd0; cfg_we1 = 1'b0; cfg_limit1 = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b expected %b", done, 4'b0000); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected %b", tick, 1'b0); end
    checks++; if (limit !== 8'd3) begin errors++; $display("FAIL reset_limit: got %0d expected %0d", limit, 3); end
    checks++; if (tick1 !== 1'b0) begin errors++; $display("FAIL reset_tick_p1: got %b expected %b", tick1, 1'b0); end
    checks++; if (limit1 !== 8'd1) begin errors++; $display("FAIL reset_limit_p1: got %0d expected %0d", limit1, 1); end
    @(negedge clk);
    reset_n   = 1'b1;
    cfg_we    = 1'b1;
    cfg_limit = 8'd7;
    for (int c = 1; c <= 7; c++) begin
      next_edge();
      cfg_we = 1'b0;
    end
    // cycle 7: tick high, every channel has counted one tick, limit is 7
    checks++; if (limit !== 8'd7) begin errors++; $display("FAIL midrun_limit: got %0d expected %0d", limit, 7); end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL midrun_tick: got %b expected %b", tick, 1'b1); end
    checks++; if (dbg_count !== 32'h01010101) begin errors++; $display("FAIL midrun_count: got %h expected %h", dbg_count, 32'h01010101); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL async_done: got %b expected %b", done, 4'b0000); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL async_tick: got %b expected %b", tick, 1'b0); end
    checks++; if (limit !== 8'd3) begin errors++; $display("FAIL async_limit: got %0d expected %0d", limit, 3); end
    checks++; if (dbg_count !== 32'h0) begin errors++; $display("FAIL async_count: got %h expected %h", dbg_count, 32'h0); end
    checks++; if (dbg_state !== 8'h00) begin errors++; $display("FAIL async_state: got %h expected %h", dbg_state, 8'h00); end
    checks++; if (tick1 !== 1'b0) begin errors++; $display("FAIL async_tick_p1: got %b expected %b", tick1, 1'b0); end
  endtask

  task test_basic_expiry();
    logic       exp_tick;
    logic [3:0] exp_done;
    apply_reset(4'h0);
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) next_edge();
      exp_tick = ((c % 4) == 3);
      exp_done = (c >= 12) ? 4'hF : 4'h0;
      checks++; if (tick !== exp_tick) begin errors++; $display("FAIL basic_tick c%0d: got %b expected %b", c, tick, exp_tick); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL basic_done c%0d: got %b expected %b", c, done, exp_done); end
    end
  endtask

  task test_clear_mid_count();
    logic [3:0] exp_done;
    apply_reset(4'h0);
    for (int c = 0; c <= 22; c++) begin
      if (c > 0) next_edge();
      exp_done = {c >= 12, c >= 12, c >= 20, c >= 12};
      checks++; if (done !== exp_done) begin errors++; $display("FAIL clear_mid c%0d: got %b expected %b", c, done, exp_done); end
      tr = (c == 8) ? 4'b0010 : 4'b0000;
    end
    tr = 4'h0;
  endtask

  task test_collision();
    logic [3:0] exp_done;
    apply_reset(4'h0);
    for (int c = 0; c <= 25; c++) begin
      if (c > 0) next_edge();
      exp_done = {c >= 12, c >= 24, c >= 12, c >= 12};
      checks++; if (done !== exp_done) begin errors++; $display("FAIL collision_done c%0d: got %b expected %b", c, done, exp_done); end
      if (c == 12) begin
        checks++; if (dbg_count[23:16] !== 8'd0) begin errors++; $display("FAIL collision_count: got %0d expected %0d", dbg_count[23:16], 0); end
        checks++; if (dbg_state[5:4] !== 2'd0) begin errors++; $display("FAIL collision_state: got %0d expected %0d", dbg_state[5:4], 0); end
      end
      tr = (c == 11) ? 4'b0100 : 4'b0000;
    end
    tr = 4'h0;
  endtask

  task test_config_zero();
    apply_reset(4'hF);
    cfg_we    = 1'b1;
    cfg_limit = 8'd0;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) next_edge();
      if (c == 1) begin
        cfg_we = 1'b0;
        checks++; if (limit !== 8'd1) begin errors++; $display("FAIL cfg_zero_limit: got %0d expected %0d", limit, 1); end
      end
      if (c >= 5) begin
        checks++; if (done[0] !== (c >= 8)) begin errors++; $display("FAIL cfg_zero_done c%0d: got %b expected %b", c, done[0], c >= 8); end
        checks++; if (done[3:1] !== 3'b000) begin errors++; $display("FAIL cfg_zero_others c%0d: got %b expected %b", c, done[3:1], 3'b000); end
      end
      tr = (c >= 4) ? 4'hE : 4'hF;
    end
  endtask

  task test_limit_lowered();
    apply_reset(4'hF);
    cfg_we    = 1'b1;
    cfg_limit = 8'd10;
    tr        = 4'hE;
    for (int c = 1; c <= 31; c++) begin
      next_edge();
      cfg_we = 1'b0;
      if (c == 20) begin
        checks++; if (dbg_count[7:0] !== 8'd5) begin errors++; $display("FAIL lower_count: got %0d expected %0d", dbg_count[7:0], 5); end
        checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL lower_pre_done: got %b expected %b", done[0], 1'b0); end
        cfg_we    = 1'b1;
        cfg_limit = 8'd2;
      end
      if (c == 21) begin
        checks++; if (limit !== 8'd2) begin errors++; $display("FAIL lower_limit: got %0d expected %0d", limit, 2); end
      end
      if (c == 23) begin
        checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL lower_before_tick: got %b expected %b", done[0], 1'b0); end
      end
      if (c == 24) begin
        checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL lower_on_tick: got %b expected %b", done[0], 1'b1); end
      end
      if (c == 25) begin
        cfg_we    = 1'b1;
        cfg_limit = 8'd50;
      end
      if (c == 26) begin
        checks++; if (limit !== 8'd50) begin errors++; $display("FAIL raise_limit: got %0d expected %0d", limit, 50); end
      end
      if (c == 30) begin
        checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL raise_stays_done: got %b expected %b", done[0], 1'b1); end
        tr = 4'hF;
      end
      if (c == 31) begin
        checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL clear_latency: got %b expected %b", done[0], 1'b0); end
        checks++; if (dbg_count[7:0] !== 8'd0) begin errors++; $display("FAIL clear_count: got %0d expected %0d", dbg_count[7:0], 0); end
      end
    end
  endtask

  task test_prescale_one();
    apply_reset(4'hF);
    checks++; if (tick1 !== 1'b0) begin errors++; $display("FAIL p1_tick_c0: got %b expected %b", tick1, 1'b0); end
    for (int c = 1; c <= 7; c++) begin
      next_edge();
      checks++; if (tick1 !== 1'b1) begin errors++; $display("FAIL p1_tick c%0d: got %b expected %b", c, tick1, 1'b1); end
      if (c == 1) begin
        checks++; if (limit1 !== 8'd1) begin errors++; $display("FAIL p1_limit: got %0d expected %0d", limit1, 1); end
      end
      if (c == 3) begin
        checks++; if (done1[0] !== 1'b0) begin errors++; $display("FAIL p1_no_stale_done: got %b expected %b", done1[0], 1'b0); end
      end
      if (c == 4 || c == 6) begin
        checks++; if (done1[0] !== 1'b1) begin errors++; $display("FAIL p1_done c%0d: got %b expected %b", c, done1[0], 1'b1); end
        checks++; if (done1[3:1] !== 3'b000) begin errors++; $display("FAIL p1_others c%0d: got %b expected %b", c, done1[3:1], 3'b000); end
      end
      if (c == 7) begin
        checks++; if (done1[0] !== 1'b0) begin errors++; $display("FAIL p1_clear: got %b expected %b", done1[0], 1'b0); end
      end
      if (c == 2) tr1 = 4'hE;
      if (c == 6) tr1 = 4'hF;
    end
  endtask

  initial begin
    test_reset();
    test_basic_expiry();
    test_clear_mid_count();
    test_collision();
    test_config_zero();
    test_limit_lowered();
    test_prescale_one();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
